alu_multicycle: RTL and testbench

//   Parametrised successor to the single-cycle datapath ALU. Registered result and

---
 rtl/alu_multicycle.sv | 145 ++++++++++++++
 tb/tb_alu_multicycle.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: registered result/Zero with start/valid handshake.
// Logic ops and ADD/SUB finish in one cycle; MUL is an iterative shift-add.
module alu_multicycle #(
  parameter int WIDTH    = 32,
  parameter int MUL_BITS = 1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  input  logic [2:0]       ALUCtrl_i,
  output logic [WIDTH-1:0] data_o,
  output logic             Zero_o,
  output logic             valid_o,
  output logic             busy_o
);

  localparam int N  = WIDTH / MUL_BITS;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b011;

  typedef enum logic {IDLE, MUL} state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             zero_q, zero_d;
  logic             valid_q, valid_d;

  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] partial;
  logic [WIDTH-1:0] acc_sum;
  logic             accept;
  logic             mul_last;

  assign accept   = start_i && (state_q == IDLE);
  assign mul_last = (state_q == MUL) && (cnt_q == LAST);

  always_comb begin
    alu_res = '0;
    case (ALUCtrl_i)
      OP_AND:  alu_res = data1_i & data2_i;
      OP_OR:   alu_res = data1_i | data2_i;
      OP_ADD:  alu_res = data1_i + data2_i;
      OP_SUB:  alu_res = data1_i - data2_i;
      default: alu_res = '0;
    endcase
  end

  // A is shifted left alongside B, so the partial product arrives pre-aligned
  // and the cnt*MUL_BITS shift never needs a barrel shifter.
  always_comb begin
    partial = '0;
    for (int j = 0; j < MUL_BITS; j++) begin
      if (b_q[j]) partial = partial + (a_q << j);
    end
    acc_sum = acc_q + partial;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && ALUCtrl_i == OP_MUL) state_d = MUL;
      MUL:     if (cnt_q == LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_o  = (state_q == MUL);
    data_o  = data_q;
    Zero_o  = zero_q;
    valid_o = valid_q;
  end

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    zero_d  = zero_q;
    valid_d = 1'b0;
    if (accept) begin
      if (ALUCtrl_i == OP_MUL) begin
        a_d   = data1_i;
        b_d   = data2_i;
        acc_d = '0;
        cnt_d = '0;
      end else begin
        data_d  = alu_res;
        zero_d  = (alu_res == '0);
        valid_d = 1'b1;
      end
    end else if (state_q == MUL) begin
      acc_d = acc_sum;
      a_d   = a_q << MUL_BITS;
      b_d   = b_q >> MUL_BITS;
      cnt_d = cnt_q + CW'(1);
      if (mul_last) begin
        cnt_d   = '0;
        data_d  = acc_sum;
        zero_d  = (acc_sum == '0);
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      zero_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      zero_q  <= zero_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle: a 32-bit/radix-2 instance and an
// 8-bit/radix-4 instance checked against hand-computed results.
module tb_alu_multicycle;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] d1, d2;
  logic [2:0]  op;
  logic [31:0] data;
  logic        zero, valid, busy;

  logic        start8;
  logic [7:0]  a8, b8;
  logic [2:0]  op8;
  logic [7:0]  data8;
  logic        zero8, valid8, busy8;

  int total = 0;
  int bad   = 0;
  int pulses;
  int busy_err;

  alu_multicycle #(.WIDTH(32), .MUL_BITS(1)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start),
    .data1_i(d1), .data2_i(d2), .ALUCtrl_i(op),
    .data_o(data), .Zero_o(zero), .valid_o(valid), .busy_o(busy)
  );

  alu_multicycle #(.WIDTH(8), .MUL_BITS(2)) dut8 (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start8),
    .data1_i(a8), .data2_i(b8), .ALUCtrl_i(op8),
    .data_o(data8), .Zero_o(zero8), .valid_o(valid8), .busy_o(busy8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic s, input logic [2:0] o,
                                input logic [31:0] a, input logic [31:0] b);
    start = s;
    op    = o;
    d1    = a;
    d2    = b;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    apply_stimulus(1'b0, 3'b000, 32'h0, 32'h0);
    start8 = 1'b0; a8 = '0; b8 = '0; op8 = 3'b000;
    repeat (2) tick();
    check_output("rst_data",  data,  32'h0);
    check_output("rst_zero",  zero,  1'b0);
    check_output("rst_valid", valid, 1'b0);
    check_output("rst_busy",  busy,  1'b0);
    rst_n = 1'b1;

    // async reset mid-cycle after a non-zero result
    apply_stimulus(1'b1, 3'b010, 32'd3, 32'd4);
    tick();
    check_output("add_3_4", data, 32'd7);
    check_output("add_3_4_valid", valid, 1'b1);
    apply_stimulus(1'b0, 3'b000, 32'h0, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    check_output("async_rst_data",  data,  32'h0);
    check_output("async_rst_valid", valid, 1'b0);
    check_output("async_rst_zero",  zero,  1'b0);
    tick();
    rst_n = 1'b1;
    pulses = 0;
    repeat (3) begin
      tick();
      if (valid) pulses++;
    end
    check_output("idle_no_valid", pulses, 0);

    // single-cycle ops, back-to-back
    apply_stimulus(1'b1, 3'b010, 32'hFFFF_FFFF, 32'h1);
    tick();
    check_output("add_wrap_data",  data,  32'h0);
    check_output("add_wrap_zero",  zero,  1'b1);
    check_output("add_wrap_valid", valid, 1'b1);
    apply_stimulus(1'b1, 3'b110, 32'd5, 32'd7);
    tick();
    check_output("sub_data",  data,  32'hFFFF_FFFE);
    check_output("sub_zero",  zero,  1'b0);
    check_output("sub_valid", valid, 1'b1);
    apply_stimulus(1'b1, 3'b111, 32'd12, 32'd34);
    tick();
    check_output("undef_data", data, 32'h0);
    check_output("undef_zero", zero, 1'b1);
    apply_stimulus(1'b1, 3'b001, 32'h0000_00F0, 32'h0000_000F);
    tick();
    check_output("or_data", data, 32'h0000_00FF);
    apply_stimulus(1'b0, 3'b010, 32'd1, 32'd1);
    tick();
    check_output("idle_valid_low", valid, 1'b0);
    check_output("idle_data_held", data, 32'h0000_00FF);

    // MUL latency 32
    apply_stimulus(1'b1, 3'b011, 32'h0001_0003, 32'h0002_0005);
    tick();
    apply_stimulus(1'b0, 3'b000, 32'h0, 32'h0);
    check_output("mul_busy_start", busy, 1'b1);
    busy_err = 0;
    for (int k = 1; k <= 31; k++) begin
      tick();
      if (busy !== 1'b1 || valid !== 1'b0) busy_err++;
    end
    check_output("mul_busy_window", busy_err, 0);
    tick();
    check_output("mul_valid", valid, 1'b1);
    check_output("mul_busy_done", busy, 1'b0);
    check_output("mul_data", data, 32'h000B_000F);
    check_output("mul_zero", zero, 1'b0);
    tick();
    check_output("mul_valid_pulse", valid, 1'b0);

    // signed MUL with start/operand noise during busy
    apply_stimulus(1'b1, 3'b011, 32'hFFFF_FFF9, 32'd3);
    tick();
    pulses = 0;
    for (int k = 1; k <= 32; k++) begin
      apply_stimulus(k[0], (k % 3 == 0) ? 3'b011 : 3'b010, 32'h1234_0000 + k, 32'd9);
      if (k == 32) start = 1'b0;
      tick();
      if (valid) pulses++;
    end
    apply_stimulus(1'b0, 3'b000, 32'h0, 32'h0);
    check_output("mul_neg_data", data, 32'hFFFF_FFEB);
    repeat (2) begin
      tick();
      if (valid) pulses++;
    end
    check_output("mul_neg_pulses", pulses, 1);

    // ADD issued in the MUL completion cycle
    apply_stimulus(1'b1, 3'b011, 32'd6, 32'd7);
    tick();
    apply_stimulus(1'b0, 3'b000, 32'h0, 32'h0);
    repeat (31) tick();
    tick();
    check_output("b2b_mul_valid", valid, 1'b1);
    check_output("b2b_mul_data", data, 32'd42);
    apply_stimulus(1'b1, 3'b010, 32'd100, 32'd23);
    tick();
    check_output("b2b_add_valid", valid, 1'b1);
    check_output("b2b_add_data", data, 32'd123);
    apply_stimulus(1'b0, 3'b000, 32'h0, 32'h0);
    tick();
    check_output("b2b_after_valid", valid, 1'b0);

    // reset aborts a MUL at iteration 10
    apply_stimulus(1'b1, 3'b011, 32'h0001_0003, 32'h0002_0005);
    tick();
    apply_stimulus(1'b0, 3'b000, 32'h0, 32'h0);
    repeat (9) tick();
    #2 rst_n = 1'b0;
    #1;
    check_output("abort_busy", busy, 1'b0);
    check_output("abort_data", data, 32'h0);
    tick();
    rst_n = 1'b1;
    pulses = 0;
    repeat (40) begin
      tick();
      if (valid || busy) pulses++;
    end
    check_output("abort_no_stale", pulses, 0);
    apply_stimulus(1'b1, 3'b000, 32'h0000_F0F0, 32'h0000_0FF0);
    tick();
    check_output("and_data", data, 32'h0000_00F0);
    check_output("and_valid", valid, 1'b1);
    apply_stimulus(1'b0, 3'b000, 32'h0, 32'h0);

    // 8-bit instance, two bits per MUL cycle: latency 4
    start8 = 1'b1; op8 = 3'b011; a8 = 8'h13; b8 = 8'h25;
    tick();
    start8 = 1'b0;
    check_output("m8_busy", busy8, 1'b1);
    busy_err = 0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      if (busy8 !== 1'b1 || valid8 !== 1'b0) busy_err++;
    end
    check_output("m8_busy_window", busy_err, 0);
    tick();
    check_output("m8_valid", valid8, 1'b1);
    check_output("m8_data", data8, 8'hBF);
    start8 = 1'b1; op8 = 3'b011; a8 = 8'hFD; b8 = 8'h05;
    tick();
    start8 = 1'b0;
    repeat (4) tick();
    check_output("m8_neg_valid", valid8, 1'b1);
    check_output("m8_neg_data", data8, 8'hF1);
    start8 = 1'b1; op8 = 3'b010; a8 = 8'hFF; b8 = 8'h01;
    tick();
    start8 = 1'b0;
    check_output("a8_wrap_data", data8, 8'h00);
    check_output("a8_wrap_zero", zero8, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
